psum_row_accumulator: RTL and testbench
=======================================

# psum_row_accumulator

Collects the pulsed partial sums a PE row emits for one output row, accumulates them across input channels in an internal line buffer, and drains the finished output row over a valid/ready stream. Sits directly below a PE row; each pass of the row over one input channel delivers one psum per output column. Generalises row output handling with configurable ofmap width, channel depth and accumulator width, plus backpressure.

## Interface
- DATA_WIDTH, 16, width of signed psum from the PE row
- ACC_WIDTH, 24, signed accumulator/output width (≥ DATA_WIDTH)
- MAX_OFMAP_WIDTH, 64, line-buffer depth (max output columns)
- MAX_CHANNELS, 16, max input channels accumulated per output row
- LOG_W = $clog2(MAX_OFMAP_WIDTH), LOG_C = $clog2(MAX_CHANNELS) (localparams)

- clk, input, 1, single clock domain
- reset, input, 1, asynchronous, active-low reset
- i_ofmap_width, input, LOG_W+1, output columns per row, latched on start
- i_num_channels, input, LOG_C+1, channels to accumulate, latched on start
- i_start, input, 1, pulse: begin a new output row
- i_psum_data, input, DATA_WIDTH, signed psum from the PE row
- i_psum_valid, input, 1, pulse qualifying i_psum_data
- i_last_psum, input, 1, final psum of a channel pass (qualified by i_psum_valid)
- o_out_data, output, ACC_WIDTH, accumulated result
- o_out_valid, output, 1, output word valid
- o_out_last, output, 1, final column of the row
- i_out_ready, input, 1, downstream accepts
- o_busy, output, 1, state != IDLE
- o_err, output, 1, sticky protocol error, cleared only by reset

## Operation
- FSM: IDLE -> ACCUM -> DRAIN -> IDLE.
- IDLE: i_start with 1 ≤ width ≤ MAX_OFMAP_WIDTH and 1 ≤ channels ≤ MAX_CHANNELS latches config, clears col/chan counters, enters ACCUM. Illegal config: start ignored, o_err set. i_start outside IDLE: ignored, no error.
- ACCUM, per accepted psum: buf[col] <= (chan==0) ? sext(psum) : buf[col] + sext(psum); col++.
- At col == width-1: col <= 0, chan++; i_last_psum must be 1 here, and 0 elsewhere; mismatch sets o_err (data still stored). When chan == channels-1 at that point -> DRAIN.
- DRAIN: rd_ptr walks 0..width-1; o_out_data = buf[rd_ptr]; advance on o_out_valid & i_out_ready; o_out_last = (rd_ptr == width-1). Handshake on last word -> IDLE.
- i_psum_valid in IDLE or DRAIN: psum dropped, o_err set.
- Arithmetic: two's complement, sign-extended psum; overflow behaviour per Configuration.

## Timing
- Reset: state IDLE, buffer and counters 0, o_out_data 0, o_out_valid 0, o_out_last 0, o_busy 0, o_err 0.
- Start accepted at edge N; psums accepted from cycle N+1. Psum in same cycle as start is dropped (o_err).
- Psums accepted back-to-back, one per cycle, no stall (no input ready).
- Final psum at edge M: o_out_valid = 1 from cycle M+1 with buf[0]; one word per cycle under continuous i_out_ready.
- o_out_data/o_out_last held stable while o_out_valid & !i_out_ready.
- o_busy deasserts the cycle after the last output handshake; next i_start accepted then.
- Reset mid-row: immediate abort to reset values, partial results discarded.

## Configuration
- PSUM_ACC_SAT_EN defined: accumulation computed at ACC_WIDTH+1 and clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; clamp does not set o_err.
- Undefined: accumulation wraps modulo 2^ACC_WIDTH.

## Test plan
- width=4, channels=1, psums 1,2,3,4 (last on 4) -> outputs 1,2,3,4, o_out_last on 4, o_err=0.
- width=3, channels=3, each pass psums 10,-5,7 -> outputs 30,-15,21; o_out_valid first asserted cycle after 9th psum.
- DRAIN with i_out_ready toggling 1,0,0,1,1 -> each word held while stalled, no loss/duplication, o_busy falls after last handshake.
- ACC_WIDTH=16, DATA_WIDTH=16, channels=2, psums 32767 twice -> 32767 with PSUM_ACC_SAT_EN, -2 without.
- i_last_psum at col 1 of width 4, then psum during DRAIN, then i_start with width=0 -> o_err set and stays 1; row result unaffected.
- Reset asserted mid-ACCUM after 5 psums -> all outputs 0 immediately; new start width=2, channels=1, psums 8,9 -> outputs 8,9.

Source files
------------

// File: rtl/psum_row_accumulator.sv
// Accumulates one PE row's psums across input channels, then drains the row as a valid/ready stream.
// First word is valid the cycle after the final psum; words hold while stalled. PSUM_ACC_SAT_EN selects saturating adds.
module psum_row_accumulator #(
  parameter int DATA_WIDTH      = 16,
  parameter int ACC_WIDTH       = 24,
  parameter int MAX_OFMAP_WIDTH = 64,
  parameter int MAX_CHANNELS    = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [$clog2(MAX_OFMAP_WIDTH):0]      i_ofmap_width,
  input  logic [$clog2(MAX_CHANNELS):0]         i_num_channels,
  input  logic                                  i_start,
  input  logic signed [DATA_WIDTH-1:0]          i_psum_data,
  input  logic                                  i_psum_valid,
  input  logic                                  i_last_psum,
  output logic signed [ACC_WIDTH-1:0]           o_out_data,
  output logic                                  o_out_valid,
  output logic                                  o_out_last,
  input  logic                                  i_out_ready,
  output logic                                  o_busy,
  output logic                                  o_err
);
  localparam int LOG_W = $clog2(MAX_OFMAP_WIDTH);
  localparam int LOG_C = $clog2(MAX_CHANNELS);
  localparam logic [LOG_W:0] W_MAX = (LOG_W+1)'(MAX_OFMAP_WIDTH);
  localparam logic [LOG_C:0] C_MAX = (LOG_C+1)'(MAX_CHANNELS);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                      state, state_nxt;
  logic [LOG_W:0]              width_q;
  logic [LOG_C:0]              chans_q;
  logic [LOG_W-1:0]            col, rd_ptr;
  logic [LOG_C-1:0]            chan;
  logic signed [ACC_WIDTH-1:0] acc_buf [MAX_OFMAP_WIDTH];

  logic                        cfg_ok, col_end, chan_end, rd_last;
  logic                        start_ok, psum_take, out_fire, err_evt;
  logic signed [ACC_WIDTH-1:0] psum_ext, acc_sum, acc_new;

  assign cfg_ok    = (i_ofmap_width != '0) && (i_ofmap_width <= W_MAX) &&
                     (i_num_channels != '0) && (i_num_channels <= C_MAX);
  assign col_end   = ({1'b0, col}    == (width_q - 1'b1));
  assign chan_end  = ({1'b0, chan}   == (chans_q - 1'b1));
  assign rd_last   = ({1'b0, rd_ptr} == (width_q - 1'b1));
  assign start_ok  = (state == IDLE) && i_start && cfg_ok;
  assign psum_take = (state == ACCUM) && i_psum_valid;
  assign out_fire  = (state == DRAIN) && i_out_ready;

  assign psum_ext  = ACC_WIDTH'(i_psum_data);

`ifdef PSUM_ACC_SAT_EN
  logic signed [ACC_WIDTH:0] wide_sum;
  always_comb begin
    wide_sum = (ACC_WIDTH+1)'(acc_buf[col]) + (ACC_WIDTH+1)'(psum_ext);
    acc_sum  = wide_sum[ACC_WIDTH-1:0];
    // Top two bits disagree only when the true sum left the ACC_WIDTH range.
    if (wide_sum[ACC_WIDTH] != wide_sum[ACC_WIDTH-1])
      acc_sum = wide_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end
`else
  assign acc_sum = acc_buf[col] + psum_ext;
`endif

  assign acc_new = (chan == '0) ? psum_ext : acc_sum;

  always_comb begin
    state_nxt   = state;
    o_out_valid = 1'b0;
    o_out_last  = 1'b0;
    o_out_data  = '0;
    o_busy      = (state != IDLE);
    err_evt     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start && !cfg_ok) err_evt = 1'b1;
        if (i_psum_valid)       err_evt = 1'b1;
        if (start_ok)           state_nxt = ACCUM;
      end
      ACCUM: begin
        if (psum_take && (i_last_psum != col_end)) err_evt = 1'b1;
        if (psum_take && col_end && chan_end)      state_nxt = DRAIN;
      end
      DRAIN: begin
        o_out_valid = 1'b1;
        o_out_last  = rd_last;
        o_out_data  = acc_buf[rd_ptr];
        if (i_psum_valid)        err_evt = 1'b1;
        if (out_fire && rd_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      width_q <= '0;
      chans_q <= '0;
      col     <= '0;
      chan    <= '0;
      rd_ptr  <= '0;
      o_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (err_evt) o_err <= 1'b1;
      if (start_ok) begin
        width_q <= i_ofmap_width;
        chans_q <= i_num_channels;
        col     <= '0;
        chan    <= '0;
        rd_ptr  <= '0;
      end
      if (psum_take) begin
        if (col_end) begin
          col  <= '0;
          chan <= chan + 1'b1;
        end else begin
          col  <= col + 1'b1;
        end
      end
      if (out_fire) rd_ptr <= rd_last ? '0 : rd_ptr + 1'b1;
    end
  end

  // Data is stored even when the last-psum marker is wrong; only o_err records it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_OFMAP_WIDTH; i++) acc_buf[i] <= '0;
    end else if (psum_take) begin
      acc_buf[col] <= acc_new;
    end
  end

endmodule

// File: tb/tb_psum_row_accumulator.sv
// Bench for psum_row_accumulator: a 24-bit and a 16-bit accumulator instance checked against a row-level model.
module tb_psum_row_accumulator;
  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PSUM_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic reset, sel, start, pvalid, plast, ready;
  logic signed [15:0] pdata;
  int cfg_w, cfg_c;
  logic [6:0] wid_a;
  logic [4:0] ch_a;
  logic [2:0] wid_b;
  logic [1:0] ch_b;
  logic signed [23:0] od_a;
  logic signed [15:0] od_b;
  logic va, la, ba, ea, vb, lb, bb, eb;
  logic mon_valid, mon_last, mon_busy, mon_err;
  longint mon_data;

  always_comb begin
    wid_a = cfg_w[6:0];
    ch_a  = cfg_c[4:0];
    wid_b = cfg_w[2:0];
    ch_b  = cfg_c[1:0];
    mon_data  = sel ? longint'(od_b) : longint'(od_a);
    mon_valid = sel ? vb : va;
    mon_last  = sel ? lb : la;
    mon_busy  = sel ? bb : ba;
    mon_err   = sel ? eb : ea;
  end

  psum_row_accumulator dut (
    .clk(clk), .reset(reset), .i_ofmap_width(wid_a), .i_num_channels(ch_a),
    .i_start(start & !sel), .i_psum_data(pdata), .i_psum_valid(pvalid & !sel),
    .i_last_psum(plast), .o_out_data(od_a), .o_out_valid(va), .o_out_last(la),
    .i_out_ready(ready), .o_busy(ba), .o_err(ea));

  psum_row_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(16), .MAX_OFMAP_WIDTH(4), .MAX_CHANNELS(2)) dut16 (
    .clk(clk), .reset(reset), .i_ofmap_width(wid_b), .i_num_channels(ch_b),
    .i_start(start & sel), .i_psum_data(pdata), .i_psum_valid(pvalid & sel),
    .i_last_psum(plast), .o_out_data(od_b), .o_out_valid(vb), .o_out_last(lb),
    .i_out_ready(ready), .o_busy(bb), .o_err(eb));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct { longint d; bit l; } exp_t;
  exp_t   exp_q[$];
  longint mdl[$];
  int     ps[$];

  // Row model: ps holds channel-major psums; each column is summed over channels.
  function automatic void build_model(int w, int c, int accw, bit sat);
    longint one = 1;
    longint hi = (one << (accw - 1)) - 1;
    longint lo = -(one << (accw - 1));
    longint m  = one << accw;
    longint s;
    mdl.delete();
    for (int col = 0; col < w; col++) begin
      s = 0;
      for (int ch = 0; ch < c; ch++) begin
        s = (ch == 0) ? longint'(ps[ch*w + col]) : s + longint'(ps[ch*w + col]);
        if (sat) begin
          if (s > hi) s = hi;
          if (s < lo) s = lo;
        end else begin
          s = (((s - lo) % m) + m) % m + lo;
        end
      end
      mdl.push_back(s);
    end
  endfunction

  // One check per cycle while the stream is valid; a word is retired on handshake.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
    end else if (mon_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", mon_valid, 0);
      end else begin
        chk("out_data", mon_data, exp_q[0].d);
        chk("out_last", mon_last, exp_q[0].l);
        if (ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(input int w, input int c, input int badcol);
    exp_t e;
    int v;
    build_model(w, c, sel ? 16 : 24, SAT);
    for (int i = 0; i < w; i++) begin
      e.d = mdl[i];
      e.l = (i == w - 1);
      exp_q.push_back(e);
    end
    cfg_w = w; cfg_c = c; start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_after_start", mon_busy, 1);
    for (int ch = 0; ch < c; ch++) begin
      for (int col = 0; col < w; col++) begin
        v = ps[ch*w + col];
        pdata  = v[15:0];
        pvalid = 1'b1;
        plast  = (col == w - 1) || (col == badcol);
        if (ch == c - 1 && col == w - 1) chk("valid_before_final", mon_valid, 0);
        tick;
        if (col == badcol) chk("err_after_bad_last", mon_err, 1);
      end
    end
    pvalid = 1'b0; plast = 1'b0;
    chk("valid_after_final", mon_valid, 1);
  endtask

  task automatic drain(input bit [7:0] pat, input int len);
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      ready = pat[k % len];
      done  = mon_valid && ready && mon_last;
      tick;
    end
    ready = 1'b0;
    chk("drain_done", done, 1);
    chk("busy_after_last", mon_busy, 0);
    chk("exp_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; sel = 1'b0; start = 1'b0; pvalid = 1'b0; plast = 1'b0;
    pdata = '0; ready = 1'b0; cfg_w = 0; cfg_c = 0;
    #3;
    chk("rst_valid", va, 0); chk("rst_last", la, 0); chk("rst_busy", ba, 0);
    chk("rst_err", ea, 0);   chk("rst_data", od_a, 0);
    chk("rst16_valid", vb, 0); chk("rst16_err", eb, 0); chk("rst16_data", od_b, 0);
    tick; tick;
    reset = 1'b1;
    tick;

    ps = '{1, 2, 3, 4};
    run_row(4, 1, -1);
    chk("t1_model_col0", mdl[0], 1);
    chk("t1_model_col3", mdl[3], 4);
    drain(8'h01, 1);
    chk("t1_err", mon_err, 0);

    ps = '{10, -5, 7, 10, -5, 7, 10, -5, 7};
    run_row(3, 3, -1);
    chk("t2_model_col0", mdl[0], 30);
    chk("t2_model_col1", mdl[1], -15);
    chk("t2_model_col2", mdl[2], 21);
    chk("t2_first_word", mon_data, 30);
    drain(8'h01, 1);

    ps = '{1, 2, 3, 4, 5, 100, -200, 300, -400, 500};
    run_row(5, 2, -1);
    chk("t3_model_col1", mdl[1], -198);
    chk("t3_model_col4", mdl[4], 505);
    drain(8'b0001_1001, 5);
    chk("t3_err", mon_err, 0);

    sel = 1'b1;
    ps = '{32767, 32767};
    run_row(1, 2, -1);
    chk("t4_model", mdl[0], SAT ? 32767 : -2);
    chk("t4_dut_word", mon_data, SAT ? 32767 : -2);
    drain(8'h01, 1);
    chk("t4_err", mon_err, 0);
    sel = 1'b0;
    tick;

    ps = '{5, 6, 7, 8};
    run_row(4, 1, 1);
    pdata = 16'sd99; pvalid = 1'b1;
    tick;
    pvalid = 1'b0;
    chk("t5_err_drain_psum", mon_err, 1);
    chk("t5_still_draining", mon_busy, 1);
    drain(8'h01, 1);
    cfg_w = 0; cfg_c = 1; start = 1'b1;
    tick;
    start = 1'b0;
    chk("t5_zero_width_ignored", mon_busy, 0);
    tick; tick;
    chk("t5_err_sticky", mon_err, 1);

    cfg_w = 4; cfg_c = 2; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pdata = 16'(i + 1); pvalid = 1'b1; plast = (i == 3);
      tick;
    end
    pvalid = 1'b0; plast = 1'b0;
    reset = 1'b0;
    #1;
    chk("t6_rst_busy", ba, 0); chk("t6_rst_valid", va, 0); chk("t6_rst_last", la, 0);
    chk("t6_rst_err", ea, 0);  chk("t6_rst_data", od_a, 0);
    tick;
    reset = 1'b1;
    tick;
    ps = '{8, 9};
    run_row(2, 1, -1);
    chk("t6_first_word", mon_data, 8);
    drain(8'h01, 1);
    chk("t6_err", mon_err, 0);

    cfg_w = 65; cfg_c = 1; start = 1'b1;
    tick;
    start = 1'b0;
    chk("t7_wide_busy", mon_busy, 0);
    chk("t7_wide_err", mon_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
